alu_control_seq: RTL and testbench

- Registered, parametrised successor to the single-cycle ALU control decoder.
- Decodes a 3-bit ALUOp and the R-format funct into ALU control, jr, sign and shift-source signals, with a one-stage valid/ready pipeline register.
- Sequences multi-cycle MULT/DIV operations with a busy counter, a start pulse and a HI/LO write-enable pulse.
- Sits between the main control/ID stage and the ALU plus the mult/div unit.

---
 rtl/alu_control_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_control_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a valid/ready stage and a MULT/DIV busy sequencer.
// Optional illegal-encoding trap enabled by defining ALUCTL_ILLEGAL_TRAP_EN.
//
// state  | meaning
// S_IDLE | accepting requests; an md op in the out_valid cycle arms the counter
// S_BUSY | mult/div unit running, counter counts down to 0
// S_DONE | final busy cycle, hilo_we pulses
module alu_control_seq #(
    parameter int FUNCT_W   = 6,
    parameter int CTRL_W    = 4,
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  alucontrol,
    output logic               jr,
    output logic               sign,
    output logic               shift_var,
    output logic [1:0]         hilo_sel,
    output logic               md_start,
    output logic [1:0]         md_op,
    output logic               md_busy,
    output logic               hilo_we,
    output logic               illegal
);

`ifdef ALUCTL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_trap;
    logic               r_md_start;
    logic               w_accept;

    logic [3:0]         w_ctrl;
    logic               w_sign, w_jr, w_shift_var, w_md, w_illegal;
    logic [1:0]         w_hilo_sel, w_md_op;

    always_comb begin
        w_ctrl      = ALU_ADD;
        w_sign      = 1'b1;
        w_jr        = 1'b0;
        w_shift_var = 1'b0;
        w_hilo_sel  = 2'b00;
        w_md        = 1'b0;
        w_md_op     = 2'b00;
        w_illegal   = 1'b0;
        unique case (alu_op)
            3'b000: w_ctrl = ALU_ADD;
            3'b001: w_ctrl = ALU_SUB;
            3'b010: begin
                case (funct)
                    FUNCT_W'(32): w_ctrl = ALU_ADD;
                    FUNCT_W'(33): begin w_ctrl = ALU_ADD;  w_sign = 1'b0; end
                    FUNCT_W'(34): w_ctrl = ALU_SUB;
                    FUNCT_W'(35): begin w_ctrl = ALU_SUB;  w_sign = 1'b0; end
                    FUNCT_W'(36): w_ctrl = ALU_AND;
                    FUNCT_W'(37): w_ctrl = ALU_OR;
                    FUNCT_W'(38): w_ctrl = ALU_XOR;
                    FUNCT_W'(39): w_ctrl = ALU_NOR;
                    FUNCT_W'(42): w_ctrl = ALU_SLT;
                    FUNCT_W'(43): begin w_ctrl = ALU_SLTU; w_sign = 1'b0; end
                    FUNCT_W'(0):  w_ctrl = ALU_SLL;
                    FUNCT_W'(2):  w_ctrl = ALU_SRL;
                    FUNCT_W'(3):  w_ctrl = ALU_SRA;
                    FUNCT_W'(4):  begin w_ctrl = ALU_SLL; w_shift_var = 1'b1; end
                    FUNCT_W'(6):  begin w_ctrl = ALU_SRL; w_shift_var = 1'b1; end
                    FUNCT_W'(7):  begin w_ctrl = ALU_SRA; w_shift_var = 1'b1; end
                    FUNCT_W'(8):  w_jr = 1'b1;
                    FUNCT_W'(16): w_hilo_sel = 2'b01;
                    FUNCT_W'(18): w_hilo_sel = 2'b10;
                    FUNCT_W'(24): begin w_md = 1'b1; w_md_op = 2'b00; end
                    FUNCT_W'(25): begin w_md = 1'b1; w_md_op = 2'b01; w_sign = 1'b0; end
                    FUNCT_W'(26): begin w_md = 1'b1; w_md_op = 2'b10; end
                    FUNCT_W'(27): begin w_md = 1'b1; w_md_op = 2'b11; w_sign = 1'b0; end
                    default:      w_illegal = 1'b1;
                endcase
            end
            3'b011: begin w_ctrl = ALU_AND;  w_sign = 1'b0; end
            3'b100: begin w_ctrl = ALU_OR;   w_sign = 1'b0; end
            3'b101: w_ctrl = ALU_SLT;
            3'b110: begin w_ctrl = ALU_SLTU; w_sign = 1'b0; end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            r_md_start <= 1'b0;
            alucontrol <= '0;
            jr         <= 1'b0;
            sign       <= 1'b0;
            shift_var  <= 1'b0;
            hilo_sel   <= 2'b00;
            md_op      <= 2'b00;
            illegal    <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            out_valid  <= w_accept;
            r_md_start <= w_accept && w_md;
            if (w_accept) begin
                alucontrol <= CTRL_W'(w_ctrl);
                jr         <= w_jr;
                sign       <= w_sign;
                shift_var  <= w_shift_var;
                hilo_sel   <= w_hilo_sel;
                md_op      <= w_md_op;
                illegal    <= TRAP_EN && w_illegal;
                if (TRAP_EN && w_illegal)
                    r_trap <= 1'b1;
            end
        end
    end

    assign md_start = r_md_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The counter is armed from the registered start pulse, so the out_valid
    // cycle itself already counts as busy and blocks new requests.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (r_md_start) begin
                    w_cnt_next = CNT_W'(MD_CYCLES - 1);
                    w_next     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0)
                    w_next = S_DONE;
                else
                    w_cnt_next = r_cnt - 1'b1;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        in_ready = (r_state == S_IDLE) && !r_md_start && !r_trap;
        md_busy  = r_md_start || (r_state != S_IDLE);
        hilo_we  = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized scoreboard bench for alu_control_seq with a cycle-level timing model.
// Honours ALUCTL_ILLEGAL_TRAP_EN when the design is built with it.
module tb_alu_control_seq;
    localparam int FUNCT_W = 6;
    localparam int CTRL_W  = 4;
    localparam int MD      = 4;
    localparam int CNT_W   = 6;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2:0]         alu_op = 3'd0;
    logic [FUNCT_W-1:0] funct = '0;
    logic               out_valid;
    logic [CTRL_W-1:0]  alucontrol;
    logic               jr, sign, shift_var, md_start, md_busy, hilo_we, illegal;
    logic [1:0]         hilo_sel, md_op;

    alu_control_seq #(.FUNCT_W(FUNCT_W), .CTRL_W(CTRL_W), .MD_CYCLES(MD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .alucontrol(alucontrol),
        .jr(jr), .sign(sign), .shift_var(shift_var), .hilo_sel(hilo_sel),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .hilo_we(hilo_we),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       jr;
        logic       sign;
        logic       shift_var;
        logic [1:0] hilo_sel;
        logic       md_start;
        logic [1:0] md_op;
        logic       illegal;
    } exp_t;

    exp_t sb_q[$];
    exp_t last = '0;
    int   checks = 0;
    int   errors = 0;
    int   age = 0;      // cycles since an md accept; 0 when no sequence runs
    bit   trap = 1'b0;
    int   flist[23] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7,
                        8, 16, 18, 24, 25, 26, 27};

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_decode(int op, int f);
        exp_t e;
        e = '0;
        e.ctrl = 4'd2;
        e.sign = 1'b1;
        case (op)
            0: e.ctrl = 4'd2;
            1: e.ctrl = 4'd6;
            2: begin
                case (f)
                    32: e.ctrl = 4'd2;
                    33: begin e.ctrl = 4'd2; e.sign = 1'b0; end
                    34: e.ctrl = 4'd6;
                    35: begin e.ctrl = 4'd6; e.sign = 1'b0; end
                    36: e.ctrl = 4'd0;
                    37: e.ctrl = 4'd1;
                    38: e.ctrl = 4'd13;
                    39: e.ctrl = 4'd12;
                    42: e.ctrl = 4'd7;
                    43: begin e.ctrl = 4'd15; e.sign = 1'b0; end
                    0, 2, 3: e.ctrl = (f == 0) ? 4'd3 : (f == 2) ? 4'd4 : 4'd5;
                    4, 6, 7: begin
                        e.ctrl = (f == 4) ? 4'd3 : (f == 6) ? 4'd4 : 4'd5;
                        e.shift_var = 1'b1;
                    end
                    8:  e.jr = 1'b1;
                    16: e.hilo_sel = 2'b01;
                    18: e.hilo_sel = 2'b10;
                    24, 25, 26, 27: begin
                        e.md_start = 1'b1;
                        e.md_op = 2'(f - 24);
                        e.sign = (f == 24 || f == 26);
                    end
                    default: e.illegal = 1'b1;
                endcase
            end
            3: begin e.ctrl = 4'd0;  e.sign = 1'b0; end
            4: begin e.ctrl = 4'd1;  e.sign = 1'b0; end
            5: e.ctrl = 4'd7;
            6: begin e.ctrl = 4'd15; e.sign = 1'b0; end
            default: e.illegal = 1'b1;
        endcase
`ifndef ALUCTL_ILLEGAL_TRAP_EN
        e.illegal = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last = '0;
            end else if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("alucontrol", int'(alucontrol), int'(e.ctrl));
                    chk("jr", jr, e.jr);
                    chk("sign", sign, e.sign);
                    chk("shift_var", shift_var, e.shift_var);
                    chk("hilo_sel", hilo_sel, e.hilo_sel);
                    chk("md_start", md_start, e.md_start);
                    if (e.md_start) chk("md_op", md_op, e.md_op);
                    chk("illegal", illegal, e.illegal);
                    last = e;
                end
            end else begin
                chk("hold_alucontrol", int'(alucontrol), int'(last.ctrl));
                chk("hold_sign", sign, last.sign);
                chk("hold_jr", jr, last.jr);
                chk("hold_shift_var", shift_var, last.shift_var);
                chk("hold_hilo_sel", hilo_sel, last.hilo_sel);
                chk("idle_md_start", md_start, 0);
            end
        end
    end

    task automatic step(bit v, int op, int f);
        bit   win, rdy;
        exp_t e;
        @(negedge clk);
        win = (age >= 1) && (age <= MD + 2);
        rdy = !win && !trap;
        chk("in_ready", in_ready, rdy);
        chk("md_busy", md_busy, win);
        chk("hilo_we", hilo_we, age == MD + 2);
        in_valid = v;
        alu_op   = 3'(op);
        funct    = FUNCT_W'(f);
        @(posedge clk);
        if (age != 0) age = (age == MD + 2) ? 0 : age + 1;
        if (v && rdy) begin
            e = ref_decode(op, f);
            sb_q.push_back(e);
            if (e.md_start) age = 1;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
            if (e.illegal) trap = 1'b1;
`endif
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alucontrol", int'(alucontrol), 0);
        chk("rst_sign", sign, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_hilo_we", hilo_we, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_illegal", illegal, 0);
    endtask

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        #1 check_reset_outputs();
        sb_q.delete();
        age  = 0;
        trap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int op, f;
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;

        foreach (flist[i]) if (flist[i] < 24) step(1, 2, flist[i]);
        foreach (flist[i]) if (flist[i] < 24) step(1, 2, flist[i]);
        for (int k = 0; k < 7; k++) step(1, k, 0);
        step(0, 0, 0);

        step(1, 2, 26);
        for (int k = 0; k < 9; k++) step(1, 2, 32 + (k % 4));
        step(0, 0, 0);

        step(1, 2, 27);
        step(0, 0, 0);
        step(0, 0, 0);
        mid_reset();
        for (int k = 0; k < MD + 6; k++) step(0, 0, 0);

        step(1, 2, 63);
        step(1, 0, 0);
        step(1, 7, 5);
        step(1, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        mid_reset();

        for (int n = 0; n < 900; n++) begin
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 2;
            f  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                               : flist[$urandom_range(0, 22)];
            step($urandom_range(0, 3) != 0, op, f);
            if (n % 250 == 249) mid_reset();
        end

        for (int k = 0; k < MD + 4; k++) step(0, 0, 0);
        chk("queue_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
